// File: rtl/memory_banked_pkg.sv
// Shared definitions for memory_banked: FSM state type, default parameter
// values and address-field width helpers.
package memory_banked_pkg;

    localparam int unsigned DEF_WORD_W = 31;
    localparam int unsigned DEF_ADDR_W = 12;
    localparam int unsigned DEF_BANKS  = 8;
    localparam int unsigned DEF_WPL    = 4;
    localparam int unsigned DEF_LINES  = 64;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCESS,
        ST_LATCH,
        ST_DONE
    } state_t;

    // Number of address bits needed to index v items (ceil(log2(v))).
    function automatic int unsigned f_log2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 31; i++) begin
            if ((32'd1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

    // Smallest power of two not below v.
    function automatic int unsigned f_pow2_ceil(input int unsigned v);
        return 32'd1 << f_log2(v);
    endfunction

    // Address bits consumed by word, line and bank fields together.
    function automatic int unsigned f_used_addr_w(input int unsigned wpl,
                                                  input int unsigned lines,
                                                  input int unsigned banks);
        return f_log2(wpl) + f_log2(lines) + f_log2(banks);
    endfunction

endpackage

// File: rtl/memory_banked_bank.sv
// One line-wide RAM bank: per-bit write mask, registered read data
// (one-cycle latency). Kept behavioural so it can be swapped for a macro.
module memory_banked_bank
    import memory_banked_pkg::*;
#(
    parameter int unsigned LINE_W = 128,
    parameter int unsigned DEPTH  = 64,
    parameter int unsigned AW     = f_log2(DEPTH)
) (
    input  logic              clk,
    input  logic              i_en,
    input  logic              i_we,
    input  logic [LINE_W-1:0] i_mask,
    input  logic [AW-1:0]     i_addr,
    input  logic [LINE_W-1:0] i_wdata,
    output logic [LINE_W-1:0] o_rdata
);

    logic [LINE_W-1:0] r_mem [DEPTH];
    logic [LINE_W-1:0] r_rdata;

    // Masked write and registered read of the addressed line.
    always_ff @(posedge clk) begin
        if (i_en) begin
            if (i_we) begin
                r_mem[i_addr] <= (r_mem[i_addr] & ~i_mask) | (i_wdata & i_mask);
            end
            r_rdata <= r_mem[i_addr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/memory_banked.sv
// Banked single-port word memory with a fixed 4-state access sequence.
// Optional per-word even parity is compiled in with MEMORY_BANKED_PARITY_EN.
module memory_banked
    import memory_banked_pkg::*;
#(
    parameter int unsigned WORD_W = DEF_WORD_W,
    parameter int unsigned ADDR_W = DEF_ADDR_W,
    parameter int unsigned BANKS  = DEF_BANKS,
    parameter int unsigned WPL    = DEF_WPL,
    parameter int unsigned LINES  = DEF_LINES
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              rd_req,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] addr,
    input  logic [WORD_W-1:0] wdata,
    output logic              busy,
    output logic              rd_done,
    output logic              wr_done,
    output logic              done,
    output logic [WORD_W-1:0] rdata,
    output logic              addr_err,
    output logic              par_err
);

`ifdef MEMORY_BANKED_PARITY_EN
    localparam int unsigned PAR_W = 1;
`else
    localparam int unsigned PAR_W = 0;
`endif

    localparam int unsigned WB     = f_log2(WPL);
    localparam int unsigned LB     = f_log2(LINES);
    localparam int unsigned BB     = f_log2(BANKS);
    localparam int unsigned USED_W = f_used_addr_w(WPL, LINES, BANKS);
    localparam int unsigned SLOT_W = f_pow2_ceil(WORD_W + PAR_W);
    localparam int unsigned LINE_W = WPL * SLOT_W;

    state_t            r_state;
    state_t            w_next;
    logic              r_op_wr;
    logic [ADDR_W-1:0] r_addr;
    logic [WORD_W-1:0] r_wdata;
    logic [WORD_W-1:0] r_rdata;

    logic [WB-1:0]     w_word;
    logic [LB-1:0]     w_line;
    logic [BB-1:0]     w_bank;
    logic              w_oor;
    logic [BANKS-1:0]  w_bank_en;
    logic [SLOT_W-1:0] w_wslot;
    logic [LINE_W-1:0] w_wline;
    logic [LINE_W-1:0] w_slot_ones;
    logic [LINE_W-1:0] w_mask;
    logic [LINE_W-1:0] w_bank_rdata [BANKS];
    logic [LINE_W-1:0] w_rshift;
    logic [WORD_W-1:0] w_rword;
    logic              w_unused;

    // Address fields come from the captured request, never the live port.
    assign w_word = r_addr[WB-1:0];
    assign w_line = r_addr[WB+LB-1:WB];
    assign w_bank = r_addr[USED_W-1:WB+LB];

    generate
        if (ADDR_W > USED_W) begin : g_hi
            assign w_oor = |r_addr[ADDR_W-1:USED_W];
        end else begin : g_nohi
            assign w_oor = 1'b0;
        end
    endgenerate

    // Build the stored slot: data, optional parity bit, zero padding.
    always_comb begin
        w_wslot                = '0;
        w_wslot[WORD_W-1:0]    = r_wdata;
`ifdef MEMORY_BANKED_PARITY_EN
        w_wslot[WORD_W]        = ^r_wdata;
`endif
    end

    assign w_wline     = {WPL{w_wslot}};
    assign w_slot_ones = LINE_W'({SLOT_W{1'b1}});
    assign w_mask      = w_slot_ones << (w_word * SLOT_W);

    generate
        for (genvar b = 0; b < BANKS; b++) begin : g_bank
            memory_banked_bank #(
                .LINE_W (LINE_W),
                .DEPTH  (LINES),
                .AW     (LB)
            ) u_bank (
                .clk     (clk),
                .i_en    (w_bank_en[b]),
                .i_we    (r_op_wr),
                .i_mask  (w_mask),
                .i_addr  (w_line),
                .i_wdata (w_wline),
                .o_rdata (w_bank_rdata[b])
            );
        end
    endgenerate

    // Selected slot shifted down to bit 0; pad bits are discarded.
    assign w_rshift = w_bank_rdata[w_bank] >> (w_word * SLOT_W);
    assign w_rword  = w_rshift[WORD_W-1:0];
    assign w_unused = ^w_rshift[LINE_W-1:WORD_W+PAR_W];

`ifdef MEMORY_BANKED_PARITY_EN
    logic r_par_err;
    logic w_par_fail;
    // Even parity over data plus stored bit must be zero.
    assign w_par_fail = ^w_rshift[WORD_W:0];
`endif

    // State register; reset aborts any operation in flight.
    always_ff @(posedge clk) begin
        if (!resetn) r_state <= ST_IDLE;
        else         r_state <= w_next;
    end

    // Next-state sequencing, bank enable and status outputs.
    always_comb begin
        w_next    = r_state;
        w_bank_en = '0;
        busy      = 1'b1;
        rd_done   = 1'b0;
        wr_done   = 1'b0;
        done      = 1'b0;
        addr_err  = 1'b0;
        par_err   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                busy = 1'b0;
                if (rd_req || wr_req) w_next = ST_ACCESS;
            end
            ST_ACCESS: begin
                if (!w_oor) w_bank_en[w_bank] = 1'b1;
                w_next = ST_LATCH;
            end
            ST_LATCH: begin
                w_next = ST_DONE;
            end
            ST_DONE: begin
                rd_done  = !r_op_wr;
                wr_done  = r_op_wr;
                done     = 1'b1;
                addr_err = w_oor;
`ifdef MEMORY_BANKED_PARITY_EN
                par_err  = !r_op_wr && r_par_err;
`endif
                w_next   = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // Request capture on acceptance (write wins) and read-data latch.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_op_wr <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
        end else begin
            if (r_state == ST_IDLE && (rd_req || wr_req)) begin
                r_op_wr <= wr_req;
                r_addr  <= addr;
                r_wdata <= wdata;
            end
            if (r_state == ST_LATCH && !r_op_wr) begin
                r_rdata <= w_oor ? '0 : w_rword;
            end
        end
    end

`ifdef MEMORY_BANKED_PARITY_EN
    // Parity verdict captured alongside the read word.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_par_err <= 1'b0;
        end else if (r_state == ST_LATCH && !r_op_wr) begin
            r_par_err <= !w_oor && w_par_fail;
        end
    end
`endif

    assign rdata = r_rdata;

endmodule
